// File: rtl/swap_cmd_ctrl_if.sv
// Request-side bundle for swap_cmd_ctrl: write and
// swap valid/ready handshakes with their payloads.
interface swap_cmd_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  sw_valid;
  logic                  sw_ready;
  logic [ADDR_WIDTH-1:0] sw_addr_a;
  logic [ADDR_WIDTH-1:0] sw_addr_b;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output sw_valid, sw_addr_a, sw_addr_b,
    input  wr_ready, sw_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  sw_valid, sw_addr_a, sw_addr_b,
    output wr_ready, sw_ready
  );
endinterface

// File: rtl/swap_cmd_ctrl.sv
// Swap command controller: queues swaps, issues writes first.
// Optional macro SWAP_FILTER_EN drops equal-address swaps.
module swap_cmd_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  swap_cmd_if.slave             req,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address_w,
  output logic [DATA_WIDTH-1:0] data_w,
  output logic                  swap,
  output logic [ADDR_WIDTH-1:0] address_A,
  output logic [ADDR_WIDTH-1:0] address_B,
  output logic                  busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]           swap_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * ADDR_WIDTH;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            starv_q, starv_d;
  logic                  we_q, we_d;
  logic                  swap_q, swap_d;
  logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
  logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [15:0]           swap_cnt_q, swap_cnt_d;

  logic fifo_empty;
  logic wr_fire;
  logic sw_fire;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);

  // Writes stall only after three in a row starve a queued swap.
  assign req.wr_ready = reset_n &
    ~((starv_q == 2'd3) & ~fifo_empty);
  assign req.sw_ready = reset_n &
    (count_q < CW'(FIFO_DEPTH));

  assign wr_fire = req.wr_valid & req.wr_ready;
  assign sw_fire = req.sw_valid & req.sw_ready;
  assign pop     = ~wr_fire & ~fifo_empty;

`ifdef SWAP_FILTER_EN
  assign push = sw_fire &
    (req.sw_addr_a != req.sw_addr_b);
`else
  assign push = sw_fire;
`endif

  // Next-state: strobes, held payloads, FIFO and guard.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    addr_w_d   = addr_w_q;
    data_w_d   = data_w_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    swap_cnt_d = swap_cnt_q;
    we_d       = wr_fire;
    swap_d     = pop;
    if (wr_fire) begin
      addr_w_d = req.wr_addr;
      data_w_d = req.wr_data;
    end
    if (pop) begin
      {addr_a_d, addr_b_d} = mem_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
      swap_cnt_d = swap_cnt_q + 16'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    starv_d = starv_q;
    if (pop | fifo_empty) begin
      starv_d = 2'd0;
    end else if (wr_fire) begin
      starv_d = starv_q + 2'd1;
    end
  end

  // Control and output registers; reset drops the queue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starv_q    <= '0;
      we_q       <= 1'b0;
      swap_q     <= 1'b0;
      addr_w_q   <= '0;
      data_w_q   <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      swap_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starv_q    <= starv_d;
      we_q       <= we_d;
      swap_q     <= swap_d;
      addr_w_q   <= addr_w_d;
      data_w_q   <= data_w_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req.sw_addr_a, req.sw_addr_b};
    end
  end

  assign we         = we_q;
  assign swap       = swap_q;
  assign address_w  = addr_w_q;
  assign data_w     = data_w_q;
  assign address_A  = addr_a_q;
  assign address_B  = addr_b_q;
  assign fifo_count = count_q;
  assign swap_cnt   = swap_cnt_q;
  assign busy       = ~fifo_empty | we_q | swap_q;
endmodule

// File: doc/swap_cmd_ctrl.md
SWAP_CMD_CTRL -- requirements
Module: swap_cmd_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, register-file address width.
REQ-002 Parameter DATA_WIDTH, default 8, register-file data width.
REQ-003 Parameter FIFO_DEPTH, default 4, swap-command FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 wr_valid / wr_ready  input / output  1 / 1  write-request handshake.
REQ-007 wr_addr / wr_data  input  ADDR_WIDTH / DATA_WIDTH  write-request address and data.
REQ-008 sw_valid / sw_ready  input / output  1 / 1  swap-request handshake.
REQ-009 sw_addr_a / sw_addr_b  input  ADDR_WIDTH each  swap-request locations.
REQ-010 we, address_w, data_w  output  1, ADDR_WIDTH, DATA_WIDTH  registered write port to the downstream swap register file.
REQ-011 swap, address_A, address_B  output  1, ADDR_WIDTH each  registered swap port to the downstream swap register file.
REQ-012 busy  output  1  high while the FIFO is non-empty or we or swap is high.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 swap_cnt  output  16  number of swaps issued since reset.

Function
REQ-015 A transfer SHALL occur on a rising edge where valid and ready are both high; the requester holds the payload stable until the transfer occurs.
REQ-016 sw_ready SHALL be high exactly when fifo_count < FIFO_DEPTH, with no same-cycle bypass from a pop.
REQ-017 A swap transfer SHALL push {sw_addr_a, sw_addr_b} into the FIFO; FIFO order SHALL be preserved.
REQ-018 A write transfer at edge k SHALL drive we=1 with address_w/data_w for exactly the one cycle after edge k; otherwise we=0.
REQ-019 At each edge with no write transfer and a non-empty FIFO, the head entry SHALL be popped and drive swap=1 with address_A/address_B for exactly the one following cycle; otherwise swap=0.
REQ-020 we and swap SHALL never be high in the same cycle; a write transfer SHALL take priority over a pop.
REQ-021 A swap accepted into an empty FIFO at edge k SHALL drive swap high after edge k+1 at the earliest.
REQ-022 Back-to-back pops SHALL produce swap high on consecutive cycles.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-024 Starvation guard: a 2-bit counter SHALL increment on each write transfer while the FIFO is non-empty, and SHALL clear on any pop or whenever the FIFO is empty.
REQ-025 When the starvation counter equals 3 and the FIFO is non-empty, wr_ready SHALL be 0; otherwise wr_ready SHALL be 1.
REQ-026 swap_cnt SHALL increment on every pop and wrap from 0xFFFF to 0x0000.
REQ-027 address_w, data_w, address_A and address_B SHALL hold their last values when their strobe is low.

Reset
REQ-028 While reset_n is low, we, swap, busy, fifo_count, swap_cnt, all address/data outputs and the starvation counter SHALL be 0.
REQ-029 While reset_n is low, wr_ready and sw_ready SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents immediately, without issuing the pending swaps.
REQ-031 The first transfer SHALL be possible on the first rising edge after reset_n rises.

Configuration
REQ-032 With macro SWAP_FILTER_EN defined, a swap transfer with sw_addr_a == sw_addr_b SHALL be acknowledged but not pushed, and SHALL never produce a swap pulse or a swap_cnt increment.
REQ-033 Without SWAP_FILTER_EN, equal-address swap requests SHALL be pushed and issued like any other request.

Verification
REQ-034 Reset, then write 20..29 at addresses 20..29 on consecutive cycles -> we high for 10 consecutive cycles, each address_w equal to data_w, and swap=0 throughout.
REQ-035 Swap request (22,28) into an idle FIFO -> swap high for exactly one cycle, 2 edges after acceptance, with address_A=22 and address_B=28, and swap_cnt=1.
REQ-036 Push 5 swaps with no pops -> sw_ready low at fifo_count=4; the fifth request is held until a pop; all issue in order.
REQ-037 Continuous wr_valid with 2 swaps queued -> wr_ready drops for one cycle after 3 writes, one swap issues, then the pattern repeats until the FIFO is empty.
REQ-038 Reset pulse with 3 swaps queued -> fifo_count=0, no swap pulse afterwards, swap_cnt=0.
REQ-039 Swap request (9,9), run once with and once without SWAP_FILTER_EN -> no pulse and swap_cnt=0 with the macro; one pulse and swap_cnt=1 without it.
